// File: rtl/binario_ascii_pkg.sv
// Shared types and constants for the binary to decimal-ASCII converter.
// Holds the FSM state type, the character slot index and ASCII helpers.
package binario_ascii_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONVERTIR,
        ENVIAR,
        FIN
    } estado_t;

    // Slot of the character currently offered on the byte stream.
    typedef enum logic [1:0] {
        IDX_C,
        IDX_D,
        IDX_U,
        IDX_CR
    } indice_t;

    localparam logic [7:0] ASCII_CERO = 8'h30;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam int         N_BITS     = 8;
    localparam int         N_DIGITOS  = 3;

    // ASCII code for a given slot, built from the three BCD digits.
    function automatic logic [7:0] caracter(
        input indice_t    idx,
        input logic [3:0] c,
        input logic [3:0] d,
        input logic [3:0] u
    );
        logic [7:0] r;
        case (idx)
            IDX_C:   r = ASCII_CERO + {4'h0, c};
            IDX_D:   r = ASCII_CERO + {4'h0, d};
            IDX_U:   r = ASCII_CERO + {4'h0, u};
            default: r = ASCII_CR;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/binario_a_ascii_ajuste.sv
// Double-dabble correction cell: add 3 to a BCD nibble that is 5 or more.
// Inputs never exceed 9, so the result always fits in 4 bits.
module ajuste_bcd (
    input  logic [3:0] digito_i,
    output logic [3:0] digito_o
);

    assign digito_o = (digito_i >= 4'd5) ? digito_i + 4'd3 : digito_i;

endmodule

// File: rtl/binario_a_ascii.sv
// Iterative binary to decimal-ASCII converter, one bit per clock,
// then streams the digits MSB first over a valid/ready byte port.
module binario_a_ascii
    import binario_ascii_pkg::*;
#(
    parameter bit SUPRIMIR_CEROS = 1'b1,
    parameter bit ENVIAR_CR      = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [N_BITS-1:0]   N,
    output logic                busy,
    output logic                done,
    output logic [3:0]          Dc,
    output logic [3:0]          Dd,
    output logic [3:0]          Du,
    output logic [7:0]          char_out,
    output logic                char_valid,
    input  logic                char_ready
);

    localparam int BCD_W = 4 * N_DIGITOS;

    estado_t            estado_q;
    logic [N_BITS-1:0]  bin_q;
    logic [BCD_W-1:0]   bcd_q;
    logic [2:0]         cnt_q;
    indice_t            idx_q;
    logic [3:0]         dc_q, dd_q, du_q;
    logic               busy_q, done_q, valid_q;
    logic [7:0]         char_q;

    logic [BCD_W-1:0]        bcd_aj;
    logic [BCD_W+N_BITS-1:0] despl;
    logic [BCD_W-1:0]        bcd_d;
    logic [N_BITS-1:0]       bin_d;
    indice_t                 primer_d;
    indice_t                 idx_d;
    logic                    ultimo;

    for (genvar g = 0; g < N_DIGITOS; g++) begin : g_ajuste
        ajuste_bcd u_ajuste (
            .digito_i (bcd_q[4*g +: 4]),
            .digito_o (bcd_aj[4*g +: 4])
        );
    end

    assign despl = {bcd_aj, bin_q} << 1;
    assign bcd_d = despl[BCD_W+N_BITS-1:N_BITS];
    assign bin_d = despl[N_BITS-1:0];
    assign idx_d = indice_t'(idx_q + 2'd1);

    // Last slot of the string: units, or the trailing CR when enabled.
    assign ultimo = (idx_q == IDX_CR) ||
                    ((idx_q == IDX_U) && !ENVIAR_CR);

    // First slot to send, skipping leading zeros when suppression is on.
    always_comb begin
        primer_d = IDX_C;
        if (SUPRIMIR_CEROS) begin
            if (bcd_d[11:8] != 4'h0)
                primer_d = IDX_C;
            else if (bcd_d[7:4] != 4'h0)
                primer_d = IDX_D;
            else
                primer_d = IDX_U;
        end
    end

    // Control FSM with conversion datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= IDLE;
            bin_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            idx_q    <= IDX_C;
            dc_q     <= '0;
            dd_q     <= '0;
            du_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            char_q   <= '0;
        end else begin
            case (estado_q)
                IDLE: begin
                    if (start) begin
                        bin_q    <= N;
                        bcd_q    <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        estado_q <= CONVERTIR;
                    end
                end
                CONVERTIR: begin
                    bin_q <= bin_d;
                    bcd_q <= bcd_d;
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        dc_q     <= bcd_d[11:8];
                        dd_q     <= bcd_d[7:4];
                        du_q     <= bcd_d[3:0];
                        idx_q    <= primer_d;
                        char_q   <= caracter(primer_d, bcd_d[11:8],
                                             bcd_d[7:4], bcd_d[3:0]);
                        valid_q  <= 1'b1;
                        estado_q <= ENVIAR;
                    end
                end
                ENVIAR: begin
                    if (valid_q && char_ready) begin
                        if (ultimo) begin
                            valid_q  <= 1'b0;
                            done_q   <= 1'b1;
                            estado_q <= FIN;
                        end else begin
                            idx_q  <= idx_d;
                            char_q <= caracter(idx_d, dc_q, dd_q, du_q);
                        end
                    end
                end
                FIN: begin
                    done_q   <= 1'b0;
                    busy_q   <= 1'b0;
                    estado_q <= IDLE;
                end
                default: estado_q <= IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign Dc         = dc_q;
    assign Dd         = dd_q;
    assign Du         = du_q;
    assign char_out   = char_q;
    assign char_valid = valid_q;

endmodule
